// File: rtl/mag_comp_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
package mag_comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Chunk index width; never zero, even when a single chunk covers the operand.
  function automatic int idx_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic bit legal_cfg(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// CHUNK-bit combinational magnitude compare; zero latency, no flow control.
// Exactly one of gt/lt/eq is asserted for any input pair.
module comp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (x > y);
  assign lt = (x < y);
  assign eq = (x == y);

endmodule

// File: rtl/mag_comp_seq.sv
// MSB-first multi-cycle compare, CHUNK bits per cycle, early exit; 1..WIDTH/CHUNK cycles.
// Backpressure: start is ignored while busy, nothing is queued.
module mag_comp_seq
  import mag_comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             more,
  output logic             less,
  output logic             equal
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = idx_width(NCH);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  if (!legal_cfg(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("mag_comp_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CHUNK-1:0] chunk_a [NCH];
  logic [CHUNK-1:0] chunk_b [NCH];
  logic [CHUNK-1:0] sel_a, sel_b;
  logic             c_gt, c_lt, c_eq;
  logic             last, finish, accept;

  for (genvar i = 0; i < NCH; i++) begin : g_slice
    assign chunk_a[i] = sh_a[WIDTH-1-i*CHUNK -: CHUNK];
    assign chunk_b[i] = sh_b[WIDTH-1-i*CHUNK -: CHUNK];
  end

  assign sel_a = chunk_a[idx];
  assign sel_b = chunk_b[idx];

  comp_chunk #(.CHUNK(CHUNK)) u_comp_chunk (
    .x  (sel_a),
    .y  (sel_b),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  assign last   = (idx == IW'(NCH - 1));
  assign busy   = (state == RUN);
  assign accept = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (!c_eq || last) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
      done  <= 1'b0;
      more  <= 1'b0;
      less  <= 1'b0;
      equal <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      // Flipping the sign bit maps two's-complement order onto unsigned order.
      if (accept) begin
        sh_a <= a ^ (signed_mode ? SIGN_MASK : '0);
        sh_b <= b ^ (signed_mode ? SIGN_MASK : '0);
        idx  <= '0;
      end else if (busy && !finish) begin
        idx <= idx + IW'(1);
      end
      if (finish) begin
        more  <= c_gt;
        less  <= c_lt;
        equal <= c_eq;
      end
    end
  end

endmodule
